// File: rtl/instr_encoder_pkg.sv
// Shared op/opcode/funct3 definitions for the instruction encoder and the
// control-unit decoder that consumes the words it writes.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    OP_LB   = 3'd0,
    OP_ORI  = 3'd1,
    OP_SB   = 3'd2,
    OP_ADD  = 3'd3,
    OP_AND  = 3'd4,
    OP_SLL  = 3'd5,
    OP_BNE  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENC,
    S_WRITE
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_ORI = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0]  F7_ZERO = 7'b0000000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: op + register/immediate fields -> RV32I word,
// with a flag for requests that cannot be encoded faithfully.
module instr_pack (
  input  logic [2:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [12:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);
  import instr_encoder_pkg::*;

  always_comb begin
    word_o    = NOP;
    illegal_o = 1'b0;
    case (op_i)
      OP_LB:   word_o = {imm_i[11:0], rs1_i, F3_LB, rd_i, OPC_LOAD};
      OP_ORI:  word_o = {imm_i[11:0], rs1_i, F3_ORI, rd_i, OPC_OP_IMM};
      OP_SB:   word_o = {imm_i[11:5], rs2_i, rs1_i, F3_SB, imm_i[4:0], OPC_STORE};
      OP_ADD:  word_o = {F7_ZERO, rs2_i, rs1_i, F3_ADD, rd_i, OPC_OP};
      OP_AND:  word_o = {F7_ZERO, rs2_i, rs1_i, F3_AND, rd_i, OPC_OP};
      OP_SLL:  word_o = {F7_ZERO, rs2_i, rs1_i, F3_SLL, rd_i, OPC_OP};
      OP_BNE: begin
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BNE,
                     imm_i[4:1], imm_i[11], OPC_BRANCH};
        illegal_o = imm_i[0];
      end
      default: illegal_o = 1'b1;
    endcase
    // I/S immediates are 12-bit signed; bit 12 must be a sign copy of bit 11.
    if ((op_i == OP_LB || op_i == OP_ORI || op_i == OP_SB) && (imm_i[12] != imm_i[11]))
      illegal_o = 1'b1;
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts one request, encodes it, writes it to the next
// instruction-memory word. Optional request checking via ENCODER_CHECK_EN.
module instr_encoder #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [12:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err
);
  import instr_encoder_pkg::*;

`ifdef ENCODER_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  localparam logic [ADDR_WIDTH:0] Capacity = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [12:0]         imm_q, imm_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                skip_q, skip_d;
  logic                err_q, err_d;
  logic [31:0]         pack_word;
  logic                pack_illegal;

  instr_pack u_pack (
    .op_i      (op_q),
    .rd_i      (rd_q),
    .rs1_i     (rs1_q),
    .rs2_i     (rs2_q),
    .imm_i     (imm_q),
    .word_o    (pack_word),
    .illegal_o (pack_illegal)
  );

  assign full      = (count_q == Capacity);
  assign in_ready  = (state_q == S_IDLE) && !full;
  // The write pointer always equals the low bits of the word count.
  assign mem_addr  = count_q[ADDR_WIDTH-1:0];
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign err       = err_q;
  assign mem_we    = (state_q == S_WRITE) && !skip_q && !clear;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    wdata_d = wdata_q;
    count_d = count_q;
    skip_d  = skip_q;
    err_d   = err_q;
    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
      skip_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            op_d    = op;
            rd_d    = rd;
            rs1_d   = rs1;
            rs2_d   = rs2;
            imm_d   = imm;
            state_d = S_ENC;
          end
        end
        S_ENC: begin
          // A flagged request still spends a cycle in WRITE, with the strobe masked.
          wdata_d = pack_word;
          skip_d  = CheckEn && pack_illegal;
          err_d   = err_q | (CheckEn && pack_illegal);
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (!skip_q) count_d = count_q + (ADDR_WIDTH+1)'(1);
          skip_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      wdata_q <= '0;
      count_q <= '0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (small memory, ADDR_WIDTH=2): vector
// table plus scoreboard of expected writes, and clear/full/check corner cases.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int unsigned AW = 2;
  localparam int unsigned CAP = 4;

  logic          clock = 1'b0;
  logic          reset, clear, in_valid, in_ready;
  logic [2:0]    op;
  logic [4:0]    rd, rs1, rs2;
  logic [12:0]   imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full, err;

  instr_encoder #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   word;
  } exp_t;

  exp_t exp_q[$];
  vec_t tab[10];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   model_cnt = 0;
  time  last_acc, prev_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input vec_t v, input bit writes, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!in_ready && n < 20) begin
      @(posedge clock); #1; n++;
    end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
      return;
    end
    op = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    in_valid = 1'b1;
    @(posedge clock);
    last_acc = $time;
    #1;
    in_valid = 1'b0;
    op = 3'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
    rs2 = 5'($urandom); imm = 13'($urandom);
    ok = 1'b1;
    if (writes) begin
      exp_q.push_back('{addr: model_cnt[AW-1:0], word: v.word});
      model_cnt++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clock); #1; n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    model_cnt = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    bit   ok, first, prev_we;
    vec_t v;
    exp_t e;

    tab[0] = '{OP_ADD, 5'd3,  5'd1,  5'd2,  13'h0000, 32'h002081B3};
    tab[1] = '{OP_LB,  5'd5,  5'd6,  5'd0,  13'h0004, 32'h00430283};
    tab[2] = '{OP_SB,  5'd0,  5'd1,  5'd2,  13'h0008, 32'h00208423};
    tab[3] = '{OP_BNE, 5'd0,  5'd1,  5'd2,  13'h1FFC, 32'hFE209EE3};
    tab[4] = '{OP_AND, 5'd10, 5'd11, 5'd12, 13'h0000, 32'h00C5F533};
    tab[5] = '{OP_SLL, 5'd1,  5'd2,  5'd3,  13'h0000, 32'h003110B3};
    tab[6] = '{OP_ORI, 5'd7,  5'd8,  5'd0,  13'h1FFF, 32'hFFF46393};
    tab[7] = '{OP_LB,  5'd31, 5'd31, 5'd17, 13'h1800, 32'h800F8F83};
    tab[8] = '{OP_SB,  5'd9,  5'd3,  5'd4,  13'h1FFF, 32'hFE418FA3};
    tab[9] = '{OP_BNE, 5'd0,  5'd5,  5'd6,  13'h0FFE, 32'h7E629FE3};

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    prev_we = 1'b0;

    fork
      forever begin
        @(negedge clock);
        if (mem_we === 1'b1) begin
          if (prev_we) begin
            n_cmp++; n_fail++;
            $display("FAIL we_width: mem_we high on consecutive cycles, required one");
          end
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_write: addr %0d data %h, required no write", mem_addr, mem_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e.addr));
            chk("wr_data", mem_wdata, e.word);
          end
        end
        prev_we = (mem_we === 1'b1);
      end
    join_none

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;

    // Vector table, back-to-back, draining and clearing whenever memory fills.
    first = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (model_cnt == CAP) begin
        drain();
        chk("batch_count", 32'(count), CAP);
        chk("batch_full", 32'(full), 32'd1);
        do_clear();
        first = 1'b1;
      end
      send(tab[i], 1'b1, ok);
      if (ok && !first) chk("accept_gap", 32'(last_acc - prev_acc), 32'd30);
      prev_acc = last_acc;
      first = !ok;
    end
    drain();
    chk("table_count", 32'(count), 32'(model_cnt));

    // Fill, hold a request off while full, then clear and restart at addr 0.
    do_clear();
    for (int i = 0; i < 4; i++) send(tab[0], 1'b1, ok);
    drain();
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), CAP);
    op = OP_ADD; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; in_valid = 1'b1;
    idle_cycles(6);
    in_valid = 1'b0;
    chk("held_count", 32'(count), CAP);
    do_clear();
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_full", 32'(full), 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd1);
    send(tab[1], 1'b1, ok);
    drain();
    chk("restart_count", 32'(count), 32'd1);

    // clear while in ENC: no write, back in IDLE.
    do_clear();
    send(tab[4], 1'b0, ok);
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    chk("clr_enc_ready", 32'(in_ready), 32'd1);
    idle_cycles(3);
    chk("clr_enc_count", 32'(count), 32'd0);

    // clear while in WRITE: strobe suppressed.
    send(tab[5], 1'b0, ok);
    @(posedge clock); #1;
    clear = 1'b1;
    @(negedge clock);
    chk("clr_wr_we", 32'(mem_we), 32'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    chk("clr_wr_ready", 32'(in_ready), 32'd1);
    idle_cycles(3);
    chk("clr_wr_count", 32'(count), 32'd0);

`ifdef ENCODER_CHECK_EN
    v = '{OP_ORI, 5'd1, 5'd0, 5'd0, 13'h0800, 32'h0};
    send(v, 1'b0, ok);
    idle_cycles(3);
    chk("chk_ori_err", 32'(err), 32'd1);
    chk("chk_ori_count", 32'(count), 32'd0);
    chk("chk_ori_ready", 32'(in_ready), 32'd1);
    do_clear();
    chk("chk_err_clr", 32'(err), 32'd0);
    v = '{OP_BNE, 5'd0, 5'd1, 5'd2, 13'h1FFD, 32'h0};
    send(v, 1'b0, ok);
    idle_cycles(3);
    chk("chk_bne_err", 32'(err), 32'd1);
    do_clear();
    v = '{OP_RSVD, 5'd0, 5'd0, 5'd0, 13'h0000, 32'h0};
    send(v, 1'b0, ok);
    idle_cycles(3);
    chk("chk_rsvd_err", 32'(err), 32'd1);
    chk("chk_rsvd_count", 32'(count), 32'd0);
    send(tab[0], 1'b1, ok);
    drain();
`else
    v = '{OP_RSVD, 5'd9, 5'd9, 5'd9, 13'h0123, NOP};
    send(v, 1'b1, ok);
    v = '{OP_BNE, 5'd0, 5'd1, 5'd2, 13'h1FFD, 32'hFE209EE3};
    send(v, 1'b1, ok);
    v = '{OP_ORI, 5'd1, 5'd0, 5'd0, 13'h0800, 32'h80006093};
    send(v, 1'b1, ok);
    drain();
    chk("nochk_err", 32'(err), 32'd0);
`endif
    idle_cycles(1);
    chk("final_count", 32'(count), 32'(model_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
